// File: rtl/sad_min_search.sv
// sad_min_search: scans a raster of (2*SR)^2 candidate SADs for one block and
// reports the smallest SAD with the displacement at which it occurred.
// Ties go to the earliest candidate in raster order (x fastest, then y).
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; last result held on the outputs
// S_RUN  | accepting one candidate per cycle that sad_valid is high
// S_DONE | result registers just updated; done pulses for one cycle

module sad_min_search #(
    parameter int SAD_WIDTH = 16,
    parameter int SR        = 8,
    parameter int MV_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        sad_valid,
    input  logic [SAD_WIDTH-1:0]        sad,
    output logic                        busy,
    output logic                        done,
    output logic [SAD_WIDTH-1:0]        min_sad,
    output logic signed [MV_WIDTH-1:0]  mv_x,
    output logic signed [MV_WIDTH-1:0]  mv_y
);

    localparam int NCAND = 4 * SR * SR;
    localparam int CNT_W = (NCAND > 1) ? $clog2(NCAND) : 1;

    localparam logic [CNT_W-1:0]           LAST_IDX = CNT_W'(NCAND - 1);
    localparam logic signed [MV_WIDTH-1:0] POS_MIN  = MV_WIDTH'(-SR);
    localparam logic signed [MV_WIDTH-1:0] POS_MAX  = MV_WIDTH'(SR - 1);
    localparam logic signed [MV_WIDTH-1:0] POS_ONE  = MV_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]           cnt_q;
    logic signed [MV_WIDTH-1:0] pos_x_q;
    logic signed [MV_WIDTH-1:0] pos_y_q;
    logic [SAD_WIDTH-1:0]       best_sad_q;
    logic signed [MV_WIDTH-1:0] best_x_q;
    logic signed [MV_WIDTH-1:0] best_y_q;

    logic launch;
    logic accept;
    logic last_cand;
    logic take;

    // Qualified events shared by the FSM and the datapath.
    always_comb begin
        launch    = (state_q == S_IDLE) && start;
        accept    = (state_q == S_RUN) && sad_valid;
        last_cand = (cnt_q == LAST_IDX);
        // First candidate is loaded unconditionally so an all-ones SAD still wins.
        take      = (cnt_q == '0) || (sad < best_sad_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (sad_valid && last_cand) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Candidate counter and raster position; frozen whenever no candidate is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else if (launch) begin
            cnt_q   <= '0;
            pos_x_q <= POS_MIN;
            pos_y_q <= POS_MIN;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (pos_x_q == POS_MAX) begin
                pos_x_q <= POS_MIN;
                pos_y_q <= pos_y_q + POS_ONE;
            end else begin
                pos_x_q <= pos_x_q + POS_ONE;
            end
        end
    end

    // Running best; strict compare keeps the earliest of equal minima.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else if (accept && take) begin
            best_sad_q <= sad;
            best_x_q   <= pos_x_q;
            best_y_q   <= pos_y_q;
        end
    end

    // Result registers load once, as the last candidate is folded in, and then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sad <= '0;
            mv_x    <= '0;
            mv_y    <= '0;
        end else if (accept && last_cand) begin
            if (take) begin
                min_sad <= sad;
                mv_x    <= pos_x_q;
                mv_y    <= pos_y_q;
            end else begin
                min_sad <= best_sad_q;
                mv_x    <= best_x_q;
                mv_y    <= best_y_q;
            end
        end
    end

endmodule
